// File: rtl/fpu_mul_sig_seq_pkg.sv
// Shared FP16 definitions for the iterative significand multiplier.
// Holds the fp16_t encoding, the format constants and the FSM state type.
package fpu_mul_sig_seq_pkg;

   localparam int FP16_EXPW    = 5;
   localparam int FP16_FRACW   = 10;
   localparam int FP16_BIAS    = 15;
   localparam int FP16_EXP_MAX = 30;
   localparam int FP16_SIGW    = 11;
   localparam int FP16_PRODW   = 22;

   typedef struct packed {
      logic                  sign;
      logic [FP16_EXPW-1:0]  exp;
      logic [FP16_FRACW-1:0] frac;
   } fp16_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fpuMulState_t;

endpackage

// File: rtl/fpu_mul_unpack.sv
// Combinational FP16 operand unpack.
//   fpuIn     : packed FP16 operand
//   sig       : significand with hidden bit, zero-extended to 12 bits
//   effExp    : effective exponent (subnormals use 1)
//   isZero    : operand is +/-0
//   isSpecial : exponent field is all ones (Inf/NaN encoding)
module fpu_mul_unpack
   import fpu_mul_sig_seq_pkg::*;
(
   input  fp16_t                fpuIn,
   output logic [11:0]          sig,
   output logic [FP16_EXPW-1:0] effExp,
   output logic                 isZero,
   output logic                 isSpecial
);

   logic expIsZero;

   assign expIsZero = (fpuIn.exp == '0);
   // 12 bits rather than 11 so that every legal digit size divides it evenly
   assign sig       = {1'b0, ~expIsZero, fpuIn.frac};
   assign effExp    = expIsZero ? FP16_EXPW'(1) : fpuIn.exp;
   assign isZero    = expIsZero && (fpuIn.frac == '0);
   assign isSpecial = &fpuIn.exp;

endmodule

// File: rtl/fpu_mul_sig_seq.sv
// Iterative FP16 multiplier front end. Accepts an operand pair on a
// valid/ready handshake, computes sign and clamped exponent at accept, then
// forms the exact 22-bit significand product BPC multiplier bits per cycle.
//   clk, rst_n            : clock, asynchronous active-low reset
//   inValid / inReady     : operand handshake (fpuIn1 multiplicand, fpuIn2 multiplier)
//   outValid / outReady   : product bundle handshake towards the normaliser
//   unnormSign/Int/Frac   : product sign and unnormalised significand (2.20)
//   unnormExp, sticky     : clamped biased exponent, sticky (always 0)
//   expOverflow/Underflow : unclamped exponent above 30 / below 1
//   specialIn             : either operand had an all-ones exponent
module fpu_mul_sig_seq
   import fpu_mul_sig_seq_pkg::*;
#(
   parameter int BPC = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inValid,
   output logic                 inReady,
   input  fp16_t                fpuIn1,
   input  fp16_t                fpuIn2,
   output logic                 outValid,
   input  logic                 outReady,
   output logic                 unnormSign,
   output logic [1:0]           unnormInt,
   output logic [19:0]          unnormFrac,
   output logic [FP16_EXPW-1:0] unnormExp,
   output logic                 sticky,
   output logic                 expOverflow,
   output logic                 expUnderflow,
   output logic                 specialIn
);

   localparam int ITERS = 12 / BPC;
   localparam int ACCW  = 24;

   fpuMulState_t stateReg, stateNext;

   logic [ACCW-1:0]      accReg, mcandReg;
   logic [11:0]          mplierReg;
   logic [3:0]           cntReg;
   logic                 signReg, ovfReg, unfReg, specialReg;
   logic [FP16_EXPW-1:0] expReg;

   logic [11:0]          sig1, sig2;
   logic [FP16_EXPW-1:0] effExp1, effExp2;
   logic                 zero1, zero2, special1, special2;
   logic                 anyZero, accept;
   logic signed [6:0]    expSum;
   logic [FP16_EXPW-1:0] expClamped;
   logic                 expOvf, expUnf;
   logic [ACCW-1:0]      mplierDigit, partial;

   fpu_mul_unpack unpack1 (
      .fpuIn(fpuIn1), .sig(sig1), .effExp(effExp1), .isZero(zero1), .isSpecial(special1)
   );

   fpu_mul_unpack unpack2 (
      .fpuIn(fpuIn2), .sig(sig2), .effExp(effExp2), .isZero(zero2), .isSpecial(special2)
   );

   assign anyZero = zero1 | zero2;

   // Range of expSum is -13..47, so 7 signed bits never wrap.
   assign expSum     = $signed({2'b00, effExp1}) + $signed({2'b00, effExp2}) - 7'sd15;
   assign expOvf     = (expSum > 7'sd30);
   assign expUnf     = (expSum < 7'sd1);
   assign expClamped = expOvf ? FP16_EXPW'(FP16_EXP_MAX) :
                       expUnf ? '0 : expSum[FP16_EXPW-1:0];

   assign mplierDigit = ACCW'(mplierReg[BPC-1:0]);
   assign partial     = mcandReg * mplierDigit;

   // Handshake and next-state logic
   always_comb begin
      stateNext = stateReg;
      inReady   = 1'b0;
      outValid  = 1'b0;
      case (stateReg)
         IDLE: inReady = 1'b1;
         BUSY: inReady = 1'b0;
         DONE: begin
            outValid = 1'b1;
            inReady  = outReady;
         end
         default: inReady = 1'b0;
      endcase
      accept = inValid & inReady;
      case (stateReg)
         IDLE: if (accept) stateNext = anyZero ? DONE : BUSY;
         BUSY: if (cntReg == '0) stateNext = DONE;
         DONE: begin
            if (accept)        stateNext = anyZero ? DONE : BUSY;
            else if (outReady) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stateReg <= IDLE;
      else        stateReg <= stateNext;
   end

   // Datapath: everything is captured at accept, then only acc/mcand/mplier
   // move during BUSY, so outputs are naturally stable while DONE holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accReg     <= '0;
         mcandReg   <= '0;
         mplierReg  <= '0;
         cntReg     <= '0;
         signReg    <= 1'b0;
         expReg     <= '0;
         ovfReg     <= 1'b0;
         unfReg     <= 1'b0;
         specialReg <= 1'b0;
      end else if (accept) begin
         accReg     <= '0;
         mcandReg   <= ACCW'(sig1);
         mplierReg  <= sig2;
         cntReg     <= 4'(ITERS - 1);
         signReg    <= fpuIn1.sign ^ fpuIn2.sign;
         specialReg <= special1 | special2;
         expReg     <= anyZero ? '0   : expClamped;
         ovfReg     <= anyZero ? 1'b0 : expOvf;
         unfReg     <= anyZero ? 1'b0 : expUnf;
      end else if (stateReg == BUSY) begin
         accReg    <= accReg + partial;
         mcandReg  <= mcandReg << BPC;
         mplierReg <= mplierReg >> BPC;
         if (cntReg != '0) cntReg <= cntReg - 4'd1;
      end
   end

   assign unnormSign   = signReg;
   assign unnormInt    = accReg[21:20];
   assign unnormFrac   = accReg[19:0];
   assign unnormExp    = expReg;
   assign sticky       = 1'b0;
   assign expOverflow  = ovfReg;
   assign expUnderflow = unfReg;
   assign specialIn    = specialReg;

endmodule

// File: tb/tb_fpu_mul_sig_seq.sv
// Bench for fpu_mul_sig_seq: BPC=1 and BPC=3 instances, directed and random
// operands checked against an arithmetic model of the FP16 product.
module tb_fpu_mul_sig_seq;
   import fpu_mul_sig_seq_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic  rstN, inValid, outReady, sel;
   fp16_t fpuIn1, fpuIn2;

   logic       inReadyA, outValidA, signA, stickyA, ovfA, unfA, specA;
   logic [1:0] intA;  logic [19:0] fracA;  logic [4:0] expA;
   logic       inReadyB, outValidB, signB, stickyB, ovfB, unfB, specB;
   logic [1:0] intB;  logic [19:0] fracB;  logic [4:0] expB;

   logic       inReadyO, outValidO;
   logic [31:0] obsBundle;

   int compareCount = 0;
   int failCount    = 0;

   fpu_mul_sig_seq #(.BPC(1)) dut (
      .clk(clk), .rst_n(rstN), .inValid(inValid & ~sel), .inReady(inReadyA),
      .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .outValid(outValidA), .outReady(outReady),
      .unnormSign(signA), .unnormInt(intA), .unnormFrac(fracA), .unnormExp(expA),
      .sticky(stickyA), .expOverflow(ovfA), .expUnderflow(unfA), .specialIn(specA)
   );

   fpu_mul_sig_seq #(.BPC(3)) dut3 (
      .clk(clk), .rst_n(rstN), .inValid(inValid & sel), .inReady(inReadyB),
      .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .outValid(outValidB), .outReady(outReady),
      .unnormSign(signB), .unnormInt(intB), .unnormFrac(fracB), .unnormExp(expB),
      .sticky(stickyB), .expOverflow(ovfB), .expUnderflow(unfB), .specialIn(specB)
   );

   always_comb begin
      inReadyO  = sel ? inReadyB  : inReadyA;
      outValidO = sel ? outValidB : outValidA;
      obsBundle = sel ? {signB, intB, fracB, expB, stickyB, ovfB, unfB, specB}
                      : {signA, intA, fracA, expA, stickyA, ovfA, unfA, specA};
   end

   // Expected bundle {sign, int[1:0], frac[19:0], exp[4:0], sticky, ovf, unf, special}
   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
      int ea, eb, sa, sb, e, ex;
      logic z, ovf, unf, spec;
      logic [21:0] p;
      ea   = int'(a[14:10]);
      eb   = int'(b[14:10]);
      sa   = int'(a[9:0]) + ((ea != 0) ? 1024 : 0);
      sb   = int'(b[9:0]) + ((eb != 0) ? 1024 : 0);
      z    = (a[14:0] == 15'd0) || (b[14:0] == 15'd0);
      p    = z ? 22'd0 : 22'(sa * sb);
      e    = ((ea == 0) ? 1 : ea) + ((eb == 0) ? 1 : eb) - 15;
      ovf  = !z && (e > 30);
      unf  = !z && (e < 1);
      ex   = z ? 0 : (e > 30) ? 30 : (e < 1) ? 0 : e;
      spec = (ea == 31) || (eb == 31);
      return {a[15] ^ b[15], p, 5'(ex), 1'b0, ovf, unf, spec};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compareCount++;
      assert (obs === expv) else begin
         failCount++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic checkOutputs(input string tag, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] m, o;
      m = model(a, b);
      o = obsBundle;
      check({tag, "_sign"},    32'(o[31]),    32'(m[31]));
      check({tag, "_int"},     32'(o[30:29]), 32'(m[30:29]));
      check({tag, "_frac"},    32'(o[28:9]),  32'(m[28:9]));
      check({tag, "_exp"},     32'(o[8:4]),   32'(m[8:4]));
      check({tag, "_sticky"},  32'(o[3]),     32'(m[3]));
      check({tag, "_ovf"},     32'(o[2]),     32'(m[2]));
      check({tag, "_unf"},     32'(o[1]),     32'(m[1]));
      check({tag, "_special"}, 32'(o[0]),     32'(m[0]));
   endtask

   // Presents operands at a negedge; returns at the negedge after the accept edge.
   task automatic launch(input string tag, input logic [15:0] a, input logic [15:0] b, input logic rdy);
      @(negedge clk);
      fpuIn1   = a;
      fpuIn2   = b;
      inValid  = 1'b1;
      outReady = rdy;
      check({tag, "_inReady"}, 32'(inReadyO), 32'd1);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      fpuIn1  = 16'($urandom);
      fpuIn2  = 16'($urandom);
   endtask

   // Counts edges from the accept edge (inclusive) until outValid shows.
   task automatic waitValid(output int edges);
      edges = 1;
      while (!outValidO && edges < 40) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
      end
   endtask

   function automatic int expLatency(input logic [15:0] a, input logic [15:0] b);
      if ((a[14:0] == 15'd0) || (b[14:0] == 15'd0)) return 1;
      return sel ? (12 / 3) + 1 : (12 / 1) + 1;
   endfunction

   task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b);
      int edges;
      launch(tag, a, b, 1'b1);
      waitValid(edges);
      check({tag, "_latency"}, 32'(edges), 32'(expLatency(a, b)));
      checkOutputs(tag, a, b);
      $display("txn %s bpc=%0d a=%h b=%h edges=%0d bundle=%h", tag, sel ? 3 : 1, a, b, edges, obsBundle);
   endtask

   initial begin
      logic [15:0] ra, rb;
      int edges;
      rstN = 1'b1; inValid = 1'b0; outReady = 1'b0; sel = 1'b0;
      fpuIn1 = '0; fpuIn2 = '0;
      #1 rstN = 1'b0;
      #1;
      check("rst_outValid", 32'(outValidO), 32'd0);
      check("rst_inReady",  32'(inReadyO),  32'd1);
      check("rst_bundle",   obsBundle,      32'd0);
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;

      runOp("one_x_one",  16'h3C00, 16'h3C00);
      runOp("p15_x_p15",  16'h3E00, 16'h3E00);
      runOp("neg1_x_2",   16'hBC00, 16'h4000);
      runOp("zero_x_max", 16'h0000, 16'h7BFF);
      runOp("max_x_max",  16'h7BFF, 16'h7BFF);
      runOp("sub_x_sub",  16'h0001, 16'h0001);
      runOp("inf_x_one",  16'h7C00, 16'h3C00);
      runOp("negz_x_inf", 16'h8000, 16'hFC00);

      // Hold in DONE with outReady low, then back-to-back accept.
      launch("hold", 16'hBC00, 16'h4000, 1'b0);
      waitValid(edges);
      check("hold_latency", 32'(edges), 32'd13);
      for (int i = 0; i < 5; i++) begin
         check("hold_outValid", 32'(outValidO), 32'd1);
         check("hold_inReady",  32'(inReadyO),  32'd0);
         checkOutputs("hold", 16'hBC00, 16'h4000);
         @(posedge clk);
         @(negedge clk);
      end
      fpuIn1 = 16'h3E00; fpuIn2 = 16'h3E00; inValid = 1'b1; outReady = 1'b1;
      #1 check("b2b_inReady", 32'(inReadyO), 32'd1);
      @(posedge clk);
      @(negedge clk);
      inValid = 1'b0;
      check("b2b_busy_outValid", 32'(outValidO), 32'd0);
      waitValid(edges);
      check("b2b_latency", 32'(edges), 32'd13);
      checkOutputs("b2b", 16'h3E00, 16'h3E00);
      $display("txn b2b bpc=1 a=3e00 b=3e00 edges=%0d bundle=%h", edges, obsBundle);

      // Asynchronous reset in the middle of BUSY.
      launch("midrst", 16'h3C00, 16'h3C00, 1'b1);
      repeat (3) @(negedge clk);
      #2 rstN = 1'b0;
      #1;
      check("midrst_outValid", 32'(outValidO), 32'd0);
      check("midrst_inReady",  32'(inReadyO),  32'd1);
      check("midrst_bundle",   obsBundle,      32'd0);
      $display("txn midrst bundle=%h", obsBundle);
      @(negedge clk);
      rstN = 1'b1;
      runOp("after_rst", 16'h3C00, 16'h3C00);

      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 7) == 0) ra[14:0] = 15'd0;
         runOp("rand_bpc1", ra, rb);
      end

      @(negedge clk);
      sel = 1'b1;
      runOp("p15_bpc3",  16'h3E00, 16'h3E00);
      runOp("zero_bpc3", 16'h8000, 16'h3C00);
      for (int i = 0; i < 10; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         runOp("rand_bpc3", ra, rb);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
